// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, default sizing,
// the wait-counter type and the word-range check.
package data_mem_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 1024;
  localparam int unsigned LATENCY_DEF     = 2;
  localparam int unsigned CNT_W           = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // True when the byte address falls inside a depth-word array.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_sram_bytemask.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are never reset.
module sram_bytemask
  import data_mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane write or registered full-word read, one per enabled cycle
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem_r[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: accepts one core request at a time, waits LATENCY cycles,
// then performs the access from captured values and pulses valid for one cycle.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        valid,
  output logic        err
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam cnt_t        LAT_CNT = cnt_t'(LATENCY);

  state_e        state_r;
  state_e        state_nxt_s;
  cnt_t          count_r;
  logic          cap_we_r;
  logic [3:0]    cap_mask_r;
  logic [31:2]   cap_addr_r;
  logic [31:0]   cap_data_r;
  logic [31:0]   load_data_r;
  logic          valid_r;
  logic          err_r;
  logic          in_range_s;
  logic          sram_en_s;
  logic          sram_we_s;
  logic [AW-1:0] sram_addr_s;
  logic [31:0]   sram_rdata_s;
  logic          unused_s;

  // Byte-offset bits never reach the word array.
  assign unused_s = ^address[1:0];

  assign in_range_s = addr_in_range({cap_addr_r, 2'b00}, DEPTH_WORDS);

  // Next-state selection for the IDLE -> WAIT -> ACCESS sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (request) begin
          state_nxt_s = (LAT_CNT == 3'd0) ? ST_ACCESS : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (count_r <= 3'd1) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACCESS: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // The read is launched on the edge entering ACCESS so the registered word is ready
  // in ACCESS; when entering straight from IDLE the address is the one being captured.
  assign sram_addr_s = (state_r == ST_IDLE) ? address[AW+1:2] : cap_addr_r[AW+1:2];
  assign sram_we_s   = !rst && (state_r == ST_ACCESS) && cap_we_r && in_range_s;
  assign sram_en_s   = sram_we_s || (!rst && (state_nxt_s == ST_ACCESS));

  sram_bytemask #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .en    (sram_en_s),
    .we    (sram_we_s),
    .be    (cap_mask_r),
    .addr  (sram_addr_s),
    .wdata (cap_data_r),
    .rdata (sram_rdata_s)
  );

  // Request capture at acceptance; later input changes cannot reach the access
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_IDLE) && request) begin
      cap_we_r   <= we_re;
      cap_mask_r <= mask;
      cap_addr_r <= address[31:2];
      cap_data_r <= store_data;
    end
  end

  // FSM, wait counter and registered completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= 3'd0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      load_data_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (request) begin
            count_r <= LAT_CNT;
          end
        end
        ST_WAIT: count_r <= count_r - 3'd1;
        ST_ACCESS: begin
          valid_r <= 1'b1;
          err_r   <= !in_range_s;
          if (!in_range_s) begin
            load_data_r <= 32'd0;
          end else if (!cap_we_r) begin
            load_data_r <= sram_rdata_s;
          end
        end
        default: count_r <= 3'd0;
      endcase
    end
  end

  assign load_data = load_data_r;
  assign valid     = valid_r;
  assign err       = err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: two controllers (LATENCY=2 and LATENCY=0) share stimulus buses;
// a word-array reference model predicts each completion, a monitor checks them.
module tb_data_mem_ctrl;

  localparam int LAT_A = 2;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, we_re;
  logic [3:0]  mask;
  logic [31:0] address, store_data;
  logic [31:0] ld_a, ld_b;
  logic        vld_a, vld_b, err_a, err_b;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] ref_last [2];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .request(req_a), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data),
    .load_data(ld_a), .valid(vld_a), .err(err_a)
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .request(req_b), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data),
    .load_data(ld_b), .valid(vld_b), .err(err_b)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference behaviour: a plain array of words, byte-merged stores, range check by value.
  function automatic exp_t model(int inst, logic we, logic [3:0] m, logic [31:0] a, logic [31:0] d);
    exp_t x;
    int   w;
    w = int'(a / 4) % 1024;
    x.cyc = 0;
    if (a >= 32'h0000_1000) begin
      x.err  = 1'b1;
      x.data = 32'd0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) ref_mem[inst][w][8*b +: 8] = d[8*b +: 8];
      end
      x.err  = 1'b0;
      x.data = ref_last[inst];
    end else begin
      x.err  = 1'b0;
      x.data = ref_mem[inst][w];
    end
    ref_last[inst] = x.data;
    return x;
  endfunction

  function automatic void mon(int inst, logic v, logic e, logic [31:0] d);
    exp_t  x;
    string tag;
    tag = (inst == 0) ? "a" : "b";
    if (v) begin
      if ((inst == 0 && q_a.size() == 0) || (inst == 1 && q_b.size() == 0)) begin
        chk({tag, "_unexpected_valid"}, 32'(v), 32'd0);
      end else begin
        x = (inst == 0) ? q_a.pop_front() : q_b.pop_front();
        chk({tag, "_latency_cycle"}, 32'(cyc), 32'(x.cyc));
        chk({tag, "_err"}, 32'(e), 32'(x.err));
        chk({tag, "_load_data"}, d, x.data);
      end
    end else begin
      chk({tag, "_err_without_valid"}, 32'(e), 32'd0);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    mon(0, vld_a, err_a, ld_a);
    mon(1, vld_b, err_b, ld_b);
  end

  // Presents one request, scrambles the inputs once it has been accepted, waits for valid.
  task automatic issue(int inst, logic we, logic [3:0] m, logic [31:0] a, logic [31:0] d, bit hold);
    exp_t x;
    bit   got;
    we_re = we; mask = m; address = a; store_data = d;
    if (inst == 0) req_a = 1'b1; else req_b = 1'b1;
    x = model(inst, we, m, a, d);
    x.cyc = cyc + 2 + ((inst == 0) ? LAT_A : 0);
    if (inst == 0) q_a.push_back(x); else q_b.push_back(x);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = (inst == 0) ? vld_a : vld_b;
      if (!got) begin
        we_re = 1'($urandom); mask = 4'($urandom);
        address = $urandom; store_data = $urandom;
      end
    end
    if (!got) chk("valid_timeout", 32'd0, 32'd1);
    if (!hold) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16)  return 32'(r * 4 + $urandom_range(0, 3));
    if (r == 16) return 32'(1023 * 4 + $urandom_range(0, 3));
    if (r == 17) return 32'h0000_1000 + ($urandom & 32'h0000_0FFF);
    if (r == 18) return $urandom | 32'h0000_1000;
    return 32'hFFFF_FFFC;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1);
  end

  initial begin
    ref_last[0] = 32'd0;
    ref_last[1] = 32'd0;
    // Requests present during reset must be dropped.
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    we_re = 1'b1; mask = 4'hF; address = 32'h20; store_data = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_load_data_a", ld_a, 32'd0);
    chk("reset_valid_a", 32'(vld_a), 32'd0);
    chk("reset_err_a", 32'(err_a), 32'd0);
    chk("reset_load_data_b", ld_b, 32'd0);
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int inst = 0; inst < 2; inst++) begin
      for (int w = 0; w < 17; w++) begin
        issue(inst, 1'b1, 4'hF, 32'(((w == 16) ? 1023 : w) * 4), $urandom, 1'b0);
      end
    end

    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'd0, 1'b0);
    issue(0, 1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 4'h0, 32'h0000_0020, 32'd0, 1'b0);
    issue(0, 1'b1, 4'b0010, 32'h0000_0020, 32'h0000_AB00, 1'b0);
    issue(0, 1'b0, 4'h3, 32'h0000_0023, 32'd0, 1'b0);
    chk("merged_byte_lane", ld_a, 32'hDEAD_ABEF);
    issue(0, 1'b0, 4'hF, 32'h0000_1000, 32'd0, 1'b0);
    issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'h5555_AAAA, 1'b0);
    issue(0, 1'b0, 4'hF, 32'h0000_0000, 32'd0, 1'b0);
    issue(0, 1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b0, 4'h0, 32'h0000_0024, 32'd0, 1'b0);
    issue(0, 1'b0, 4'hF, 32'h0000_0FFC, 32'd0, 1'b0);

    // Reset two and three edges after acceptance: in WAIT, then in ACCESS.
    for (int k = 2; k < 4; k++) begin
      we_re = 1'b1; mask = 4'hF; address = 32'h0000_0014; store_data = 32'hCAFE_F00D;
      req_a = 1'b1;
      repeat (k) @(posedge clk);
      #1;
      rst = 1'b1; req_a = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ref_last[0] = 32'd0;
      ref_last[1] = 32'd0;
      chk("abort_load_data_cleared", ld_a, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      issue(0, 1'b0, 4'hF, 32'h0000_0014, 32'd0, 1'b0);
    end

    repeat (150) begin
      issue(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), rnd_addr(), $urandom, 1'b0);
    end

    // Request held across two loads on the zero-latency controller.
    issue(1, 1'b0, 4'hF, 32'h0000_0000, 32'd0, 1'b1);
    issue(1, 1'b0, 4'hF, 32'h0000_0008, 32'd0, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    chk("a_pending_at_end", 32'(q_a.size()), 32'd0);
    chk("b_pending_at_end", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
